// File: rtl/alu_seq_unit.sv
// Sequential ALU for the execute stage. It takes one operation per start/done
// handshake. Logic, arithmetic, compare and shift ops take one cycle. MUL, DIVU
// and REMU take WIDTH shift-add or restoring-subtract iterations. Results are
// registered and held until the next completion.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             of
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_XOR  = 4'h2, OP_NOR  = 4'h3,
    OP_ADD  = 4'h4, OP_SUB  = 4'h5, OP_SLT  = 4'h6, OP_SLL  = 4'h7,
    OP_SRL  = 4'h8, OP_SRA  = 4'h9, OP_SLTU = 4'hA, OP_MUL  = 4'hB,
    OP_DIVU = 4'hC, OP_REMU = 4'hD, OP_IL0  = 4'hE, OP_IL1  = 4'hF
  } op_e;

  // S_DONE is the cycle that commits the result. S_RESP is the cycle that
  // presents the done pulse.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_RESP} state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;    // product or remainder : multiplier or quotient
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zf_q, zf_d, of_q, of_d;

  logic [WIDTH-1:0] sum_w, dif_w;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge, start_iter;
  logic [WIDTH-1:0] res_val;
  logic             of_val;

  assign sum_w = a_q + b_q;
  assign dif_w = a_q - b_q;

  // A multiply step adds the multiplicand when the multiplier LSB is set.
  // The {carry, hi, lo} value then shifts right by one.
  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};

  // A divide step moves the next dividend bit into the partial remainder.
  // It subtracts the divisor when the remainder fits. When B==0 every step
  // subtracts nothing. That leaves quotient = all ones and remainder = A.
  assign rem_sh  = {hi_q, lo_q[MSB]};
  assign rem_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - b_q;

  assign start_iter = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);

  // Final result and overflow flag, selected from the latched operation.
  always_comb begin
    res_val = '0;
    of_val  = 1'b0;
    case (op_q)
      OP_AND:  res_val = a_q & b_q;
      OP_OR:   res_val = a_q | b_q;
      OP_XOR:  res_val = a_q ^ b_q;
      OP_NOR:  res_val = ~(a_q | b_q);
      OP_ADD: begin
        res_val = sum_w;
        of_val  = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_val = dif_w;
        of_val  = (a_q[MSB] != b_q[MSB]) && (dif_w[MSB] != a_q[MSB]);
      end
      OP_SLT:  res_val = WIDTH'($signed(a_q) < $signed(b_q));
      OP_SLL:  res_val = b_q << a_q[SHW-1:0];
      OP_SRL:  res_val = b_q >> a_q[SHW-1:0];
      OP_SRA:  res_val = $signed(b_q) >>> a_q[SHW-1:0];
      OP_SLTU: res_val = WIDTH'(a_q < b_q);
      OP_MUL: begin
        res_val = lo_q;
        of_val  = |hi_q;
      end
      OP_DIVU: begin
        res_val = lo_q;
        of_val  = (b_q == '0);
      end
      OP_REMU: begin
        res_val = hi_q;
        of_val  = (b_q == '0);
      end
      default: begin
        res_val = '0;
        of_val  = 1'b1;
      end
    endcase
  end

  // Next-state logic: accept, iterate, commit, then pulse done.
  always_comb begin
    // NOTE: every signal gets a default first. Without it, a path that skips
    // an assignment would infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zf_d     = zf_q;
    of_d     = of_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_e'(alu_op);
          a_d     = data_a;
          b_d     = data_b;
          hi_d    = '0;
          lo_d    = data_a;
          cnt_d   = '0;
          state_d = start_iter ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        if (op_q == OP_MUL) begin
          {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
        end else begin
          hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], rem_ge};
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = res_val;
        zf_d     = (res_val == '0);
        of_d     = of_val;
        state_d  = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample its value from
    // before the edge, independent of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_RESP);
  assign result = result_q;
  assign zf     = zf_q;
  assign of     = of_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit. It runs directed corner cases and
// random operations. An arithmetic reference model supplies result, of and
// latency.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, zf, of;
  logic [3:0]   alu_op;
  logic [W-1:0] data_a, data_b, result;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] prev_res = '0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
    .result(result), .zf(zf), .of(of)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference model: expected result, overflow flag and latency.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic o, output int lat);
    longint      s;
    logic [63:0] p;
    logic [4:0]  sh;
    sh  = a[4:0];
    o   = 1'b0;
    lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3: r = ~(a | b);
      4'h4: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = s[31:0];
        o = (s != longint'($signed(r)));
      end
      4'h5: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        o = (s != longint'($signed(r)));
      end
      4'h6: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'h7: r = b << sh;
      4'h8: r = b >> sh;
      4'h9: r = $signed(b) >>> sh;
      4'hA: r = (a < b) ? 32'd1 : 32'd0;
      4'hB: begin
        p   = {32'h0, a} * {32'h0, b};
        r   = p[31:0];
        o   = (p[63:32] != 0);
        lat = W + 1;
      end
      4'hC: begin
        r   = (b == 0) ? 32'hFFFF_FFFF : a / b;
        o   = (b == 0);
        lat = W + 1;
      end
      4'hD: begin
        r   = (b == 0) ? a : a % b;
        o   = (b == 0);
        lat = W + 1;
      end
      default: begin
        r = '0;
        o = 1'b1;
      end
    endcase
  endtask

  // Issue one op, check handshake timing and the outputs, return to idle.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         eo;
    int           elat, lat;
    model(op, a, b, er, eo, elat);
    @(negedge clk);
    start  = 1'b1;
    alu_op = op;
    data_a = a;
    data_b = b;
    @(posedge clk); #1;
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
    check($sformatf("busy_after_accept op%0h", op), busy, 1);
    lat = 0;
    while (!done && lat < 100) begin
      check($sformatf("result_stable op%0h", op), result, prev_res);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0h", op), lat, elat);
    check($sformatf("result op%0h a=%0h b=%0h", op, a, b), result, er);
    check($sformatf("zf op%0h", op), zf, (er == 0));
    check($sformatf("of op%0h", op), of, eo);
    check($sformatf("busy_with_done op%0h", op), busy, 1);
    prev_res = er;
    @(posedge clk); #1;
    check($sformatf("done_single_pulse op%0h", op), done, 0);
    check($sformatf("busy_released op%0h", op), busy, 0);
  endtask

  initial begin
    int n_done, lat;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; alu_op = '0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset zf", zf, 0);
    check("reset of", of, 0);
    @(negedge clk) rst = 1'b0;

    // Directed corner cases
    run_op(4'h4, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(4'h5, 32'd5, 32'd5);
    run_op(4'h6, 32'hFFFF_FFFF, 32'd1);
    run_op(4'hA, 32'hFFFF_FFFF, 32'd1);
    run_op(4'h9, 32'd4, 32'h8000_0000);
    run_op(4'h8, 32'd4, 32'h8000_0000);
    run_op(4'h7, 32'd33, 32'h0000_0003);
    run_op(4'h5, 32'h8000_0000, 32'd1);
    run_op(4'hB, 32'h0001_0000, 32'h0001_0000);
    run_op(4'hB, 32'd1234, 32'd5678);
    run_op(4'hC, 32'd100, 32'd7);
    run_op(4'hD, 32'd100, 32'd7);
    run_op(4'hC, 32'd9, 32'd0);
    run_op(4'hD, 32'd9, 32'd0);
    run_op(4'hE, 32'd3, 32'd4);
    run_op(4'hF, 32'd0, 32'd0);
    run_op(4'h3, 32'd0, 32'd0);

    // A start during a MUL is dropped: there is exactly one done, and it
    // carries the MUL result.
    @(negedge clk);
    start = 1'b1; alu_op = 4'hB; data_a = 32'd3; data_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; alu_op = 4'h4; data_a = 32'd1; data_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored_start mul result", result, 21);
    check("ignored_start mul of", of, 0);
    n_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("ignored_start extra done", n_done, 0);
    prev_res = 32'd21;

    // A reset at DIVU iteration 10 aborts the operation.
    @(negedge clk);
    start = 1'b1; alu_op = 4'hC; data_a = 32'd1000; data_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort of", of, 0);
    @(negedge clk) rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort no done", n_done, 0);
    prev_res = '0;
    run_op(4'hD, 32'd1000, 32'd3);

    // When start and reset arrive in the same cycle, reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; alu_op = 4'h4; data_a = 32'd1; data_b = 32'd2;
    @(posedge clk); #1;
    check("rst_start busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("rst_start no done", n_done, 0);
    check("rst_start result", result, 0);
    prev_res = '0;

    // Random operations
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 5) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
      b  = ($urandom_range(0, 6) == 0) ? 32'd0
         : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
      run_op(op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
